// File: rtl/segway_pkg.sv
// Shared defaults, types and helpers for the segway drive-math datapath.
package segway_pkg;

  localparam int CW_D       = 12;
  localparam int SS_W_D     = 8;
  localparam int MIN_DUTY_D = 168;
  localparam int LOW_BAND_D = 42;
  localparam int FAST_THR_D = 1536;

  typedef logic signed [CW_D-1:0] spd_t;

  function automatic int sat_to_cw(input int v, input int cw);
    int hi;
    int lo;
    hi = (1 << (cw - 1)) - 1;
    lo = -(1 << (cw - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/segway_drive_math_p_deadzn.sv
// Dead-zone shaper: offset large torques by MIN_DUTY, boost small ones,
// then saturate to the CW-bit signed range.
module deadzn_shaper_p
  import segway_pkg::*;
#(
  parameter int CW         = CW_D,
  parameter int MIN_DUTY   = MIN_DUTY_D,
  parameter int LOW_BAND   = LOW_BAND_D,
  parameter int SMALL_SHFT = 2
) (
  input  logic signed [CW:0]   trq,
  output logic signed [CW-1:0] shaped
);

  localparam int W = CW + 4;
  localparam logic signed [W-1:0] LB = W'(LOW_BAND);
  localparam logic signed [W-1:0] MD = W'(MIN_DUTY);

  logic signed [W-1:0] t_w;
  logic signed [W-1:0] mag;
  logic signed [W-1:0] res;

  always_comb begin
    t_w = W'(trq);
    mag = t_w[W-1] ? -t_w : t_w;
    if (mag > LB)
      res = t_w[W-1] ? t_w - MD : t_w + MD;
    else
      res = t_w <<< SMALL_SHFT;
    shaped = CW'(sat_to_cw(int'(res), CW));
  end

endmodule

// File: rtl/segway_drive_math_p.sv
// Pipelined drive math: soft-start, steer mix, dead zone, slew limit
// and persistence-filtered overspeed detection.
module segway_drive_math_p
  import segway_pkg::*;
#(
  parameter int CW         = CW_D,
  parameter int SS_W       = SS_W_D,
  parameter int STEER_NUM  = 3,
  parameter int STEER_SHFT = 4,
  parameter int MIN_DUTY   = MIN_DUTY_D,
  parameter int LOW_BAND   = LOW_BAND_D,
  parameter int SMALL_SHFT = 2,
  parameter int SLEW_MAX   = 256,
  parameter int FAST_THR   = FAST_THR_D,
  parameter int TF_PERSIST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic signed [CW-1:0] PID_cntrl,
  input  logic [CW-1:0]        steer_pot,
  input  logic                 en_steer,
  input  logic                 pwr_up,
  output logic signed [CW-1:0] lft_spd,
  output logic signed [CW-1:0] rgt_spd,
  output logic                 out_vld,
  output logic                 too_fast,
  output logic                 ss_done
);

  localparam int PW = CW + SS_W + 1;
  localparam int SW = CW + 6;
  localparam int TW = $clog2(TF_PERSIST + 1);
  localparam logic [CW-1:0] POT_LO = CW'(1 << (CW - 3));
  localparam logic [CW-1:0] POT_HI = CW'(7 << (CW - 3));
  localparam logic signed [SW-1:0] CTR = SW'((1 << (CW - 1)) - 1);
  localparam logic [7:0] SN = 8'(STEER_NUM);
  localparam logic signed [CW:0] SMX = (CW+1)'(SLEW_MAX);
  localparam logic signed [CW:0] FT  = (CW+1)'(FAST_THR);
  localparam logic [TW-1:0] TF_MAX = TW'(TF_PERSIST);

  logic [SS_W-1:0] ss_cnt;
  logic signed [PW-1:0] prod;
  logic signed [CW-1:0] pid_ss;
  logic [CW-1:0] pot_c;
  logic signed [SW-1:0] st_c;
  logic signed [SW-1:0] st_m;
  logic signed [CW-1:0] steer;

  logic v1, v2;
  logic en_q;
  logic signed [CW-1:0] pid_q, steer_q;
  logic signed [CW:0] trq_l, trq_r;
  logic signed [CW-1:0] shp_l, shp_r;
  logic signed [CW-1:0] tgt_l, tgt_r;
  logic [TW-1:0] tf_cnt;

  function automatic logic signed [CW-1:0] slew(
    input logic signed [CW-1:0] tgt,
    input logic signed [CW-1:0] prev
  );
    logic signed [CW:0] d;
    d = {tgt[CW-1], tgt} - {prev[CW-1], prev};
    if (d > SMX)
      d = SMX;
    else if (d < -SMX)
      d = -SMX;
    return CW'({prev[CW-1], prev} + d);
  endfunction

  function automatic logic over(input logic signed [CW-1:0] t);
    logic signed [CW:0] e;
    e = {t[CW-1], t};
    if (e[CW])
      e = -e;
    return e > FT;
  endfunction

  // S1 combinational: soft-start scale and steering term
  always_comb begin
    prod = PW'(PID_cntrl) * PW'($signed({1'b0, ss_cnt}));
    pid_ss = CW'(prod >>> SS_W);
    if (steer_pot < POT_LO)
      pot_c = POT_LO;
    else if (steer_pot > POT_HI)
      pot_c = POT_HI;
    else
      pot_c = steer_pot;
    st_c = $signed(SW'(pot_c)) - CTR;
    st_m = '0;
    for (int b = 0; b < 8; b++)
      if (SN[b])
        st_m = st_m + (st_c <<< b);
    steer = CW'(st_m >>> STEER_SHFT);
  end

  always_comb begin
    trq_l = {pid_q[CW-1], pid_q};
    trq_r = {pid_q[CW-1], pid_q};
    if (en_q) begin
      trq_l = trq_l + {steer_q[CW-1], steer_q};
      trq_r = trq_r - {steer_q[CW-1], steer_q};
    end
  end

  deadzn_shaper_p #(
    .CW(CW), .MIN_DUTY(MIN_DUTY),
    .LOW_BAND(LOW_BAND), .SMALL_SHFT(SMALL_SHFT)
  ) u_dz_l (
    .trq(trq_l), .shaped(shp_l)
  );

  deadzn_shaper_p #(
    .CW(CW), .MIN_DUTY(MIN_DUTY),
    .LOW_BAND(LOW_BAND), .SMALL_SHFT(SMALL_SHFT)
  ) u_dz_r (
    .trq(trq_r), .shaped(shp_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_cnt  <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      out_vld <= 1'b0;
      en_q    <= 1'b0;
      pid_q   <= '0;
      steer_q <= '0;
      tgt_l   <= '0;
      tgt_r   <= '0;
      lft_spd <= '0;
      rgt_spd <= '0;
      tf_cnt  <= '0;
    end else begin
      v1      <= in_vld;
      v2      <= v1;
      out_vld <= v2;
      if (!pwr_up)
        ss_cnt <= '0;
      else if (in_vld && ss_cnt != '1)
        ss_cnt <= ss_cnt + 1'b1;
      if (in_vld) begin
        pid_q   <= pid_ss;
        steer_q <= steer;
        en_q    <= en_steer;
      end
      if (v1) begin
        tgt_l <= pwr_up ? shp_l : '0;
        tgt_r <= pwr_up ? shp_r : '0;
      end
      // losing drive enable zeroes the wheels at once, no slew
      if (!pwr_up) begin
        lft_spd <= '0;
        rgt_spd <= '0;
        tf_cnt  <= '0;
      end else if (v2) begin
        lft_spd <= slew(tgt_l, lft_spd);
        rgt_spd <= slew(tgt_r, rgt_spd);
        if (!(over(tgt_l) || over(tgt_r)))
          tf_cnt <= '0;
        else if (tf_cnt != TF_MAX)
          tf_cnt <= tf_cnt + 1'b1;
      end
    end
  end

  assign too_fast = tf_cnt >= TF_MAX;
  assign ss_done  = &ss_cnt;

endmodule

// File: tb/tb_segway_drive_math_p.sv
// Directed bench for segway_drive_math_p with hand-computed expectations.
module tb_segway_drive_math_p;

  logic clk = 1'b0;
  logic rst_n;
  logic in_vld;
  logic signed [11:0] PID_cntrl;
  logic [11:0] steer_pot;
  logic en_steer;
  logic pwr_up;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rgt_spd;
  logic out_vld;
  logic too_fast;
  logic ss_done;

  int errors = 0;
  int checks = 0;

  segway_drive_math_p dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld),
    .PID_cntrl(PID_cntrl), .steer_pot(steer_pot),
    .en_steer(en_steer), .pwr_up(pwr_up),
    .lft_spd(lft_spd), .rgt_spd(rgt_spd),
    .out_vld(out_vld), .too_fast(too_fast), .ss_done(ss_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n back-to-back samples, then wait until the last one emerges
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1;
      step();
    end
    in_vld = 1'b0;
    step();
    step();
    chk("run_out_vld", int'(out_vld), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_vld = 1'b0;
    PID_cntrl = '0;
    steer_pot = 12'h800;
    en_steer = 1'b0;
    pwr_up = 1'b0;
    step();
    step();
    chk("rst_lft", lft_spd, 0);
    chk("rst_rgt", rgt_spd, 0);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_tf", int'(too_fast), 0);
    chk("rst_ssd", int'(ss_done), 0);
    rst_n = 1'b1;
    step();

    // soft-start ramp
    pwr_up = 1'b1;
    PID_cntrl = 12'sh400;
    for (int i = 0; i < 300; i++) begin
      in_vld = 1'b1;
      step();
      if (i == 0) chk("lat_c1", int'(out_vld), 0);
      if (i == 1) chk("lat_c2", int'(out_vld), 0);
      if (i == 2) chk("lat_c3", int'(out_vld), 1);
      if (i == 3) chk("ramp_s1", lft_spd, 16);
      if (i == 13) chk("ramp_s11", lft_spd, 212);
      if (i == 13) chk("ramp_s11r", rgt_spd, 212);
      if (i == 253) chk("ssd_254", int'(ss_done), 0);
      if (i == 254) chk("ssd_255", int'(ss_done), 1);
    end
    in_vld = 1'b0;
    step();
    step();
    chk("ss_vld", int'(out_vld), 1);
    chk("ss_lft", lft_spd, 1188);
    chk("ss_rgt", rgt_spd, 1188);
    step();
    chk("idle_vld", int'(out_vld), 0);
    chk("idle_hold", lft_spd, 1188);
    chk("ss_done_sat", int'(ss_done), 1);

    // small signal, slew down from 1188
    PID_cntrl = 12'sd40;
    run(1);
    chk("slew_dn", lft_spd, 932);
    run(5);
    chk("small_l", lft_spd, 156);
    chk("small_r", rgt_spd, 156);

    // steering at clamp limits
    PID_cntrl = 12'sd0;
    steer_pot = 12'hFFF;
    en_steer = 1'b1;
    run(1);
    chk("st1_l", lft_spd, 412);
    chk("st1_r", rgt_spd, -100);
    run(1);
    chk("st2_l", lft_spd, 456);
    chk("st2_r", rgt_spd, -356);
    run(1);
    chk("st3_l", lft_spd, 456);
    chk("st3_r", rgt_spd, -456);
    steer_pot = 12'h000;
    run(4);
    chk("stlo_l", lft_spd, -456);
    chk("stlo_r", rgt_spd, 456);

    // dead-zone boundary
    en_steer = 1'b0;
    PID_cntrl = 12'sd43;
    run(3);
    chk("dz42_l", lft_spd, 168);
    chk("dz42_r", rgt_spd, 168);
    PID_cntrl = 12'sd44;
    run(1);
    chk("dz43", lft_spd, 211);
    PID_cntrl = -12'sd44;
    run(2);
    chk("dzneg", lft_spd, -212);

    // overspeed persistence
    PID_cntrl = 12'sh7FF;
    run(3);
    chk("tf_3", int'(too_fast), 0);
    run(1);
    chk("tf_4", int'(too_fast), 1);
    chk("tf_lft", lft_spd, 812);
    PID_cntrl = 12'sh800;
    run(2);
    chk("tf_neg", int'(too_fast), 1);
    PID_cntrl = 12'sd0;
    run(1);
    chk("tf_clr", int'(too_fast), 0);
    PID_cntrl = 12'sd1374;
    run(4);
    chk("tf_eq_thr", int'(too_fast), 0);
    PID_cntrl = 12'sd1375;
    run(4);
    chk("tf_abv_thr", int'(too_fast), 1);
    PID_cntrl = 12'sd0;
    run(1);
    chk("tf_clr2", int'(too_fast), 0);

    // saturation through slew, then reset mid-flight
    PID_cntrl = 12'sh400;
    run(14);
    chk("back_1188", lft_spd, 1188);
    PID_cntrl = 12'sh7FF;
    run(4);
    chk("sat_lft", lft_spd, 2047);
    chk("sat_tf", int'(too_fast), 1);
    in_vld = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("mrst_lft", lft_spd, 0);
    chk("mrst_rgt", rgt_spd, 0);
    chk("mrst_tf", int'(too_fast), 0);
    chk("mrst_ssd", int'(ss_done), 0);
    in_vld = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst_novld", int'(out_vld), 0);
    end
    chk("mrst_lft2", lft_spd, 0);

    // drive enable drop bypasses slew
    PID_cntrl = 12'sh400;
    run(300);
    chk("pw_pre", lft_spd, 1188);
    pwr_up = 1'b0;
    run(1);
    chk("pw_lft", lft_spd, 0);
    chk("pw_rgt", rgt_spd, 0);
    chk("pw_ssd", int'(ss_done), 0);
    chk("pw_tf", int'(too_fast), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
